// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The state encoding and default timing constants match those used by the UART top.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } arb_state_t;

  localparam int BYTE_W           = 8;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_BAUD         = 9600;
  // One 10-bit frame at 9600 baud on a 100 MHz clock is about 104k cycles.
  // The timeout leaves roughly 2x margin over that.
  localparam int DEF_DONE_TIMEOUT = 200_000;
  localparam int DEF_LOCK_TIMEOUT = 20_000;

  // Number of bits needed to hold the larger of two cycle limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake plus transmitter-side start/busy/done bus.
// The master modport is the arbiter. The slave modport is the clients and the transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_data, tx_start
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It returns the first asserted request scanning from rr_ptr upward, wrapping modulo NUM_REQ.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = req[(int'(rr_ptr) + i) % NUM_REQ];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    any = 1'b0;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        any = 1'b1;
        off = IDX_W'(k);
      end
    end
  end

  // Undo the rotation. The sum is wrapped by hand because NUM_REQ need not be a power of two.
  always_comb begin
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    winner = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers.
// Grants are round-robin per message; a message runs until req_last and is never interleaved.
// A stuck transmitter is aborted after DONE_TIMEOUT cycles.
// A requester that idles mid-message for LOCK_TIMEOUT cycles loses its grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(DONE_TIMEOUT, LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               last_flag;
  logic [7:0]         tx_byte;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   lock_cnt;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;
  logic [IDX_W-1:0]   accept_idx;
  logic [7:0]         accept_data;
  logic               accept_last;
  logic [NUM_REQ-1:0] ready;

  // Next requester after id, modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] id);
    return (id == IDX_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Decide which requester, if any, has its byte consumed this cycle.
  // In IDLE the round-robin winner is accepted. In HOLD only the locked owner is considered.
  always_comb begin
    accept     = 1'b0;
    accept_idx = grant_id;
    case (state)
      ST_IDLE: begin
        accept     = pick_any;
        accept_idx = pick_idx;
      end
      ST_HOLD: begin
        accept = bus.req_valid[grant_id];
      end
      default: begin
        accept = 1'b0;
      end
    endcase
    if (rst) begin
      accept = 1'b0;
    end
  end

  assign accept_data = bus.req_data[int'(accept_idx) * BYTE_W +: BYTE_W];
  assign accept_last = bus.req_last[accept_idx];

  // One-hot ready pulse towards the accepted requester.
  always_comb begin
    ready = '0;
    if (accept) begin
      ready[accept_idx] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_data   = tx_byte;
  // Start is issued from the LAUNCH state and only while the transmitter is free.
  // Leaving LAUNCH on the same edge limits the pulse to exactly one cycle.
  assign bus.tx_start  = (state == ST_LAUNCH) && !bus.tx_busy && !rst;

  // Arbiter FSM: grant, launch, wait for frame completion, hold the lock between bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      last_flag    <= 1'b0;
      tx_byte      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
      lock_cnt     <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_byte      <= accept_data;
            last_flag    <= accept_last;
            grant_id     <= accept_idx;
            grant_active <= 1'b1;
            state        <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          if (!bus.tx_busy) begin
            // The start cycle itself counts as the first waited cycle.
            // With this, the abort lands exactly DONE_TIMEOUT cycles after tx_start.
            wait_cnt <= CNT_W'(1);
            state    <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (bus.tx_done) begin
            if (last_flag) begin
              rr_ptr       <= ptr_after(grant_id);
              grant_active <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              lock_cnt <= '0;
              state    <= ST_HOLD;
            end
          end else if (wait_cnt >= DONE_LAST) begin
            // The transmitter never finished. Drop the rest of the message and re-arbitrate.
            timeout_err  <= 1'b1;
            rr_ptr       <= ptr_after(grant_id);
            grant_active <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end

        ST_HOLD: begin
          if (accept) begin
            tx_byte   <= accept_data;
            last_flag <= accept_last;
            state     <= ST_LAUNCH;
          end else if (lock_cnt >= LOCK_LAST) begin
            // Owner went quiet mid-message. Release as if its last byte had gone out.
            rr_ptr       <= ptr_after(grant_id);
            grant_active <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            lock_cnt <= sat_inc(lock_cnt);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
